// File: rtl/muxbus_master_if.sv
// Bundle between a CPU core, the multiplexed-bus master and the pad multiplexer.
// The master modport is the view of muxbus_master; the slave modport is the view of everything around it.
interface muxbus_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WAIT_WIDTH = 4
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [WAIT_WIDTH-1:0] cfg_wait;
  logic                  ext_ready;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] bus_out;
  logic [DATA_WIDTH-1:0] bus_in;
  logic                  bus_dir;
  logic                  latch_enable;
  logic                  OEb;
  logic                  WEb;

  modport master (
    input  req, we, addr, wdata, cfg_wait, ext_ready, bus_in,
    output busy, done, err, rdata, bus_out, bus_dir, latch_enable, OEb, WEb
  );

  modport slave (
    output req, we, addr, wdata, cfg_wait, ext_ready, bus_in,
    input  busy, done, err, rdata, bus_out, bus_dir, latch_enable, OEb, WEb
  );
endinterface

// File: rtl/muxbus_master.sv
// Multiplexed address/data bus master: address + latch, hold, turnaround/setup,
// strobe with wait states and ready extension (with timeout), recovery.
module muxbus_master #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_CYCLES = 1,
  parameter int WAIT_WIDTH  = 4,
  parameter int MAX_EXT     = 255
) (
  input logic             clk,
  input logic             rst_n,
  muxbus_master_if.master bus
);

  localparam int ACNT_W = (ADDR_CYCLES > 1) ? $clog2(ADDR_CYCLES) : 1;
  localparam int EXT_W  = (MAX_EXT > 1) ? $clog2(MAX_EXT + 1) : 1;
  localparam bit TMO_EN = (MAX_EXT > 0);
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ADDR_CYCLES - 1);
  localparam logic [EXT_W-1:0]  EXT_MAX   = EXT_W'(MAX_EXT);

  typedef enum logic [3:0] {
    IDLE, ADDR, AHOLD, TURN, RSTB, RREC, WSETUP, WSTB, WREC
  } state_t;

  state_t                state_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WAIT_WIDTH-1:0] wait_q;
  logic [WAIT_WIDTH-1:0] scnt_q;
  logic [ACNT_W-1:0]     acnt_q;
  logic [EXT_W-1:0]      ext_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] bus_out_q;
  logic                  bus_dir_q;
  logic                  le_q;
  logic                  oeb_q;
  logic                  web_q;
  logic [ADDR_WIDTH-1:0] addr_s;

  assign addr_s = bus.addr;

  // Bus-cycle sequencer; every output is a register updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wait_q    <= '0;
      scnt_q    <= '0;
      acnt_q    <= '0;
      ext_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      bus_out_q <= '0;
      bus_dir_q <= 1'b1;
      le_q      <= 1'b0;
      oeb_q     <= 1'b1;
      web_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            state_q   <= ADDR;
            we_q      <= bus.we;
            wdata_q   <= bus.wdata;
            wait_q    <= bus.cfg_wait;
            acnt_q    <= '0;
            busy_q    <= 1'b1;
            bus_dir_q <= 1'b0;
            bus_out_q <= DATA_WIDTH'(addr_s);
            le_q      <= 1'b1;
          end else begin
            busy_q    <= 1'b0;
            bus_dir_q <= 1'b1;
          end
        end
        ADDR: begin
          if (acnt_q == ACNT_LAST) begin
            state_q <= AHOLD;
            le_q    <= 1'b0;
          end else begin
            acnt_q <= acnt_q + 1'b1;
          end
        end
        // Address stays on the bus one more cycle so the latch closes on stable data.
        AHOLD: begin
          if (we_q) begin
            state_q   <= WSETUP;
            bus_out_q <= wdata_q;
          end else begin
            state_q   <= TURN;
            bus_dir_q <= 1'b1;
          end
        end
        TURN: begin
          state_q <= RSTB;
          oeb_q   <= 1'b0;
          scnt_q  <= '0;
          ext_q   <= '0;
        end
        WSETUP: begin
          state_q <= WSTB;
          web_q   <= 1'b0;
          scnt_q  <= '0;
          ext_q   <= '0;
        end
        // Minimum W+1 strobe cycles, then ready extension bounded by the timeout.
        RSTB, WSTB: begin
          if (scnt_q != wait_q) begin
            scnt_q <= scnt_q + 1'b1;
          end else if (bus.ext_ready || (TMO_EN && (ext_q == EXT_MAX))) begin
            state_q <= (state_q == RSTB) ? RREC : WREC;
            oeb_q   <= 1'b1;
            web_q   <= 1'b1;
            done_q  <= 1'b1;
            err_q   <= ~bus.ext_ready;
            if ((state_q == RSTB) && bus.ext_ready) begin
              rdata_q <= bus.bus_in;
            end
          end else begin
            ext_q <= ext_q + 1'b1;
          end
        end
        RREC, WREC: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          bus_dir_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          bus_dir_q <= 1'b1;
          le_q      <= 1'b0;
          oeb_q     <= 1'b1;
          web_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.bus_out      = bus_out_q;
  assign bus.bus_dir      = bus_dir_q;
  assign bus.latch_enable = le_q;
  assign bus.OEb          = oeb_q;
  assign bus.WEb          = web_q;

endmodule
